// File: rtl/mealy_seq_detector.sv
// rtl/mealy_seq_detector.sv - parametrised Mealy sequence detector with saturating match counter
// Optional runtime pattern register is enabled by defining SEQDET_PAT_LOAD_EN.
module mealy_seq_detector #(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in,
  input  logic             cnt_clr,
`ifdef SEQDET_PAT_LOAD_EN
  input  logic             pat_wr,
  input  logic [PAT_W-1:0] pat_data,
`endif
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int               FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [PAT_W-2:0]  hist, hist_n;
  logic [FILL_W-1:0] fill, fill_n;
  logic [PAT_W-1:0]  word;
  logic [PAT_W-1:0]  pat;
  logic              load;
  logic              match;

  assign word = {hist, in};

`ifdef SEQDET_PAT_LOAD_EN
  logic [PAT_W-1:0] pat_q, pat_n;
  assign pat  = pat_q;
  assign load = pat_wr;
`else
  assign pat  = PATTERN;
  assign load = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      hist <= '0;
      fill <= '0;
`ifdef SEQDET_PAT_LOAD_EN
      pat_q <= PATTERN;
`endif
    end else begin
      hist <= hist_n;
      fill <= fill_n;
`ifdef SEQDET_PAT_LOAD_EN
      pat_q <= pat_n;
`endif
    end
  end

  // Next-state logic; a pattern load restarts the fill so stale history cannot match
  always_comb begin
    hist_n = hist;
    fill_n = fill;
    if (in_valid) begin
      hist_n = word[PAT_W-2:0];
      if (match && !OVERLAP) begin
        fill_n = '0;
      end else if (fill != FILL_MAX) begin
        fill_n = fill + 1'b1;
      end
    end
    if (load) begin
      fill_n = '0;
    end
`ifdef SEQDET_PAT_LOAD_EN
    pat_n = pat_wr ? pat_data : pat_q;
`endif
  end

  // Output logic
  always_comb begin
    match = reset & in_valid & ~load & (fill == FILL_MAX) & (word == pat);
    out   = match;
  end

  // Match counter; clear has priority over an increment in the same cycle
  always_ff @(posedge clk) begin
    if (!reset || cnt_clr) begin
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else if (match && (match_cnt != CNT_MAX)) begin
      match_cnt <= match_cnt + 1'b1;
      cnt_sat   <= (match_cnt == (CNT_MAX - 1'b1));
    end
  end

endmodule

// File: tb/tb_mealy_seq_detector.sv
// tb/tb_mealy_seq_detector.sv - bench for mealy_seq_detector: three configurations, bit-window model
// Instances: 0 = overlap CNT_W 8, 1 = non-overlap CNT_W 8, 2 = overlap CNT_W 2.
module tb_mealy_seq_detector;

  localparam int PAT_W = 4;

  logic       clk = 1'b0;
  logic       reset, in_valid, din, cnt_clr;
  logic       pat_wr;
  logic [3:0] pat_data;
  logic [2:0] out_w, sat_w;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  int n_chk  = 0;
  int n_fail = 0;

  // model state: window of accepted bits, how many are valid, count
  int win [3];
  int len [3];
  int cnt [3];
  int cmax[3] = '{255, 255, 3};
  bit ov  [3] = '{1'b1, 1'b0, 1'b1};
  int pat = 11;
  bit [15:0] rec [3];

  always #5 clk = ~clk;

  mealy_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(din), .cnt_clr(cnt_clr),
`ifdef SEQDET_PAT_LOAD_EN
    .pat_wr(pat_wr), .pat_data(pat_data),
`endif
    .out(out_w[0]), .match_cnt(cnt0), .cnt_sat(sat_w[0]));

  mealy_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(din), .cnt_clr(cnt_clr),
`ifdef SEQDET_PAT_LOAD_EN
    .pat_wr(pat_wr), .pat_data(pat_data),
`endif
    .out(out_w[1]), .match_cnt(cnt1), .cnt_sat(sat_w[1]));

  mealy_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(din), .cnt_clr(cnt_clr),
`ifdef SEQDET_PAT_LOAD_EN
    .pat_wr(pat_wr), .pat_data(pat_data),
`endif
    .out(out_w[2]), .match_cnt(cnt2), .cnt_sat(sat_w[2]));

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int dut_cnt(input int k);
    if (k == 0) return int'(cnt0);
    if (k == 1) return int'(cnt1);
    return int'(cnt2);
  endfunction

  // One clock: drive, check every instance against the model at negedge, advance model
  task automatic cyc(input bit v, input bit b, input bit rst = 1'b1, input bit clr = 1'b0,
                     input bit pw = 1'b0, input int pd = 0);
    bit em;
    int cand;
    reset = rst; in_valid = v; din = b; cnt_clr = clr; pat_wr = pw; pat_data = pd[3:0];
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      cand = ((win[k] << 1) | int'(b)) & ((1 << PAT_W) - 1);
      em = rst && v && !pw && (len[k] >= PAT_W - 1) && (cand == pat);
      chk($sformatf("out%0d", k), int'(out_w[k]), int'(em));
      chk($sformatf("cnt%0d", k), dut_cnt(k), cnt[k]);
      chk($sformatf("sat%0d", k), int'(sat_w[k]), int'(cnt[k] == cmax[k]));
      rec[k] = {rec[k][14:0], out_w[k]};
      if (!rst) begin
        win[k] = 0; len[k] = 0; cnt[k] = 0;
      end else begin
        if (v) begin
          if (em && !ov[k]) begin
            len[k] = 0;
          end else begin
            win[k] = cand;
            if (len[k] < PAT_W - 1) len[k]++;
          end
        end
        if (pw) len[k] = 0;
        if (clr) cnt[k] = 0;
        else if (em && cnt[k] < cmax[k]) cnt[k]++;
      end
    end
    if (!rst) pat = 11;
    else if (pw) pat = pd & 15;
    @(posedge clk);
    #1;
  endtask

  task automatic rec_clr();
    for (int k = 0; k < 3; k++) rec[k] = '0;
  endtask

  task automatic feed(input int bits, input int n);
    for (int i = n - 1; i >= 0; i--) cyc(1'b1, bit'((bits >> i) & 1));
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; din = 1'b0; cnt_clr = 1'b0; pat_wr = 1'b0; pat_data = '0;
    for (int k = 0; k < 3; k++) begin win[k] = 0; len[k] = 0; cnt[k] = 0; end
    @(posedge clk); #1;

    // reset for two cycles with data present, then partial fill 1,0,1
    rec_clr();
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    feed(5, 3);
    chk("fill_out", int'(rec[0][4:0]), 0);
    chk("fill_cnt", int'(cnt0), 0);
    chk("fill_sat", int'(sat_w[0]), 0);

    // overlapping vs non-overlapping on 1011011
    cyc(1'b0, 1'b0, 1'b0);
    rec_clr();
    feed(7'b1011011, 7);
    chk("ovl_out", int'(rec[0][6:0]), 7'b0001001);
    chk("novl_out", int'(rec[1][6:0]), 7'b0001000);
    chk("ovl_cnt", int'(cnt0), 2);
    chk("novl_cnt", int'(cnt1), 1);
    cyc(1'b1, 1'b1);
    chk("novl_bit8", int'(out_w[1]), 0);
    chk("novl_rec8", int'(rec[1][0]), 0);

    // gaps with in=1 are transparent
    cyc(1'b0, 1'b0, 1'b0);
    rec_clr();
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1); cyc(1'b0, 1'b1); cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b1);
    chk("gap_out", int'(rec[0][6:0]), 7'b0000001);
    chk("gap_cnt", int'(cnt0), 1);

    // reset mid-pattern discards history; then a full fresh pattern matches
    rec_clr();
    feed(5, 3);
    cyc(1'b1, 1'b1, 1'b0);
    feed(4'b1011, 4);
    chk("rstmid_out", int'(rec[0][7:0]), 8'b00000001);
    chk("rstmid_cnt", int'(cnt0), 1);

    // saturation at CNT_W=2, then clear colliding with a 5th match
    cyc(1'b0, 1'b0, 1'b0);
    feed(13'b1011011011011, 13);
    chk("sat_cnt2", int'(cnt2), 3);
    chk("sat_flag2", int'(sat_w[2]), 1);
    chk("sat_cnt0", int'(cnt0), 4);
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_out", int'(rec[2][0]), 1);
    chk("clr_cnt2", int'(cnt2), 0);
    chk("clr_sat2", int'(sat_w[2]), 0);
    cyc(1'b1, 1'b0);

`ifdef SEQDET_PAT_LOAD_EN
    // load 0110 on a cycle that would have matched 1011
    cyc(1'b0, 1'b0, 1'b0);
    rec_clr();
    feed(5, 3);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6);
    chk("load_out", int'(rec[0][0]), 0);
    chk("load_cnt", int'(cnt0), 0);
    rec_clr();
    feed(9'b101110110, 9);
    chk("newpat_out", int'(rec[0][8:0]), 9'b000000001);
    chk("newpat_cnt", int'(cnt0), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mealy_seq_detector.md
Name: mealy_seq_detector

Overview:
- Parametrised Mealy sequence detector that replaces the fixed single-pattern Mealy FSM.
- Detects a PAT_W-bit serial pattern on a 1-bit input stream qualified by a valid strobe.
- Supports overlapping and non-overlapping match modes.
- Counts matches in a saturating counter. Sits on serial-bit front ends; out feeds downstream event logic in the same cycle.

Parameters:
PAT_W, 4, pattern length in bits; legal range 2..16.
PATTERN, 4'b1011, target sequence; MSB is the first bit received.
OVERLAP, 1, 1 = overlapping matches allowed; 0 = history discarded after each match.
CNT_W, 8, width of match counter.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
in_valid  in  1  qualifies in; state advances only when 1.
in  in  1  serial data bit.
cnt_clr  in  1  synchronous clear of match_cnt and cnt_sat.
out  out  1  Mealy match flag, combinational from current state, in and in_valid.
match_cnt  out  CNT_W  number of matches since reset/clear, saturating.
cnt_sat  out  1  high while match_cnt is all-ones.

Behaviour:
- State:
  - hist[PAT_W-2:0] holds the last PAT_W-1 accepted bits, newest at LSB.
  - fill counts accepted bits, 0..PAT_W-1, saturating at PAT_W-1.
  - Phases: FILL while fill<PAT_W-1; HUNT when fill==PAT_W-1.
- Reset (reset==0 at a rising edge):
  - hist=0, fill=0 (FILL), match_cnt=0, cnt_sat=0.
  - out=0 while reset is low, regardless of in and in_valid.
- Match condition: match = reset & in_valid & (fill==PAT_W-1) & ({hist,in}==PATTERN).
  - out = match, zero latency. out is valid in the same cycle as the final pattern bit.
- On an edge with in_valid=1 and no reset:
  - hist <= {hist[PAT_W-3:0], in}.
  - fill <= min(fill+1, PAT_W-1).
  - If match and OVERLAP==0: fill <= 0 (back to FILL). hist still shifts but is ignored until refilled.
  - If match and OVERLAP==1: fill stays PAT_W-1 (HUNT), so a suffix of the match can start the next one.
- in_valid=0: hist and fill hold; out=0; gaps of any length are transparent to the detector.
- Counter:
  - On match, match_cnt increments; it saturates at 2^CNT_W-1.
  - cnt_sat is registered, =1 exactly when match_cnt==all-ones.
  - Further matches still drive out=1 but do not wrap the count.
- Simultaneous cnt_clr and match: cnt_clr wins; match_cnt=0, cnt_sat=0. out still pulses. Detector state advances normally.
- cnt_clr does not affect hist or fill.
- reset mid-pattern: partial history is discarded; a full PAT_W new bits are needed before any match.
- Width rules: the {hist,in} comparison is exactly PAT_W bits. The fill counter is $clog2(PAT_W) bits wide.

Optional Feature:
- Macro SEQDET_PAT_LOAD_EN.
- Defined:
  - Adds ports pat_wr (in, 1) and pat_data (in, PAT_W).
  - A runtime pattern register, reset to PATTERN, is loaded from pat_data on any edge with pat_wr=1.
  - The same edge forces fill <= 0, so no match is possible until PAT_W further valid bits arrive.
  - out is 0 in a cycle with pat_wr=1.
  - Matching always uses the register.
- Undefined: ports are absent and the pattern is the constant PATTERN.

Test Plan:
- Reset and FILL: reset=0 for 2 cycles, then bits 1,0,1 valid -> out=0 throughout, match_cnt=0, cnt_sat=0.
- Overlap: OVERLAP=1, PATTERN=1011, stream 1,0,1,1,0,1,1 with in_valid=1 -> out=1 on bits 4 and 7 only; match_cnt=2.
- Non-overlap: OVERLAP=0, same stream -> out=1 on bit 4 only; match_cnt=1. Then bit 1 (bits 5-8 = 0111) -> still no match.
- Valid gaps and reset mid-pattern:
  - Stream 1,0,(in_valid=0 for 3 cycles, in=1),1,1 -> single match on the last bit.
  - Separately, 1,0,1 then reset pulse then 1 -> no match.
- Saturation and clear priority:
  - CNT_W=2, 4 matches -> match_cnt=3, cnt_sat=1.
  - cnt_clr asserted in the same cycle as a 5th match -> out=1, next cycle match_cnt=0, cnt_sat=0.
- SEQDET_PAT_LOAD_EN: pat_wr with pat_data=0110 mid-stream -> out=0 that cycle; old pattern 1011 no longer matches; 0,1,1,0 then matches with out=1 on the last bit.
